// File: rtl/display_pkg.sv
// Shared types and constants for the occupancy display path.
package display_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] BCD_NINE = 4'h9;

    // Largest value representable with the given number of decimal digits.
    function automatic longint unsigned max_decimal(input int unsigned digits);
        longint unsigned p;
        p = 64'd1;
        for (int unsigned i = 0; i < digits; i++) begin
            p = p * 64'd10;
        end
        return p - 64'd1;
    endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble digit correction: add 3 to any BCD digit of 5 or more.
module bcd_digit_adjust (
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    assign o_digit = (i_digit >= 4'd5) ? (i_digit + 4'd3) : i_digit;

endmodule

// File: rtl/bin_to_bcd_serial.sv
// Serial shift-and-add-3 binary-to-BCD converter with start/done handshake
// and saturation to all nines when the input exceeds the display range.
module bin_to_bcd_serial
    import display_pkg::*;
#(
    parameter int unsigned BIN_W  = 16,
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [BIN_W-1:0]      binary_i,
    output logic                  ready_o,
    output logic                  done_o,
    output logic [4*DIGITS-1:0]   bcd_o,
    output logic                  overflow_o
);

    localparam int unsigned     BCD_W    = 4 * DIGITS;
    localparam longint unsigned MAX_DEC  = max_decimal(DIGITS);
    localparam bit              CAN_OVF  = (BIN_W >= 64) ? 1'b1
                                         : (((64'd1 << BIN_W) - 64'd1) > MAX_DEC);
    localparam int unsigned     CNT_W    = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIN_W - 1);

    state_t             r_state;
    logic [BIN_W-1:0]   r_shift;
    logic [BCD_W-1:0]   r_work;
    logic [BCD_W-1:0]   r_bcd;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ovf_pend;
    logic               r_ready;
    logic               r_done;
    logic               r_overflow;

    logic [BCD_W-1:0]   w_adj;
    logic [BCD_W-1:0]   w_work_next;
    logic [BIN_W-1:0]   w_shift_next;
    logic               w_drop;
    logic               w_ovf_in;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .i_digit (r_work[4*g +: 4]),
            .o_digit (w_adj[4*g +: 4])
        );
    end

    assign {w_drop, w_work_next, w_shift_next} = {w_adj, r_shift, 1'b0};

    if (CAN_OVF) begin : g_ovf
        localparam logic [BIN_W-1:0] MAX_BIN = BIN_W'(MAX_DEC);
        assign w_ovf_in = (binary_i > MAX_BIN);
    end else begin : g_no_ovf
        assign w_ovf_in = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_work     <= '0;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_ovf_pend <= 1'b0;
            r_ready    <= 1'b1;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_shift    <= binary_i;
                        r_work     <= '0;
                        r_cnt      <= CNT_LOAD;
                        r_ovf_pend <= w_ovf_in;
                        r_ready    <= 1'b0;
                        r_state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_work     <= w_work_next;
                    r_shift    <= w_shift_next;
                    // A bit leaving the top digit implies overflow; folding it in
                    // keeps the pending flag consistent without changing results.
                    r_ovf_pend <= r_ovf_pend | w_drop;
                    if (r_cnt == '0) begin
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                DONE: begin
                    r_bcd      <= r_ovf_pend ? {DIGITS{BCD_NINE}} : r_work;
                    r_overflow <= r_ovf_pend;
                    r_done     <= 1'b1;
                    r_ready    <= 1'b1;
                    r_state    <= IDLE;
                end
                default: begin
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ready_o    = r_ready;
    assign done_o     = r_done;
    assign bcd_o      = r_bcd;
    assign overflow_o = r_overflow;

endmodule

// File: tb/tb_bin_to_bcd_serial.sv
// Directed and random checks of bin_to_bcd_serial against a decimal reference model.
module tb_bin_to_bcd_serial;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] binary;
    logic        ready_o;
    logic        done_o;
    logic [15:0] bcd_o;
    logic        overflow_o;

    int total = 0;
    int bad   = 0;

    bin_to_bcd_serial #(
        .BIN_W  (16),
        .DIGITS (4)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (start),
        .binary_i   (binary),
        .ready_o    (ready_o),
        .done_o     (done_o),
        .bcd_o      (bcd_o),
        .overflow_o (overflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] ref_bcd(input int unsigned v);
        logic [15:0] r;
        int unsigned t;
        if (v > 9999) return 16'h9999;
        r = '0;
        t = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One conversion from an idle DUT; optionally pokes start_i with a new value mid-flight.
    task automatic do_conv(input logic [15:0] v, input bit poke);
        int n;
        int ready_bad;
        int extra;
        @(negedge clk);
        binary = v;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        ready_bad = 0;
        while (n < 40) begin
            @(posedge clk); #1;
            n++;
            if (poke && n == 5) begin
                start  = 1'b1;
                binary = 16'd300;
            end
            if (poke && n == 6) start = 1'b0;
            if (done_o) break;
            if (ready_o !== 1'b0) ready_bad++;
        end
        check("latency", n, 17);
        check("ready_busy", ready_bad, 0);
        check("bcd", {16'h0, bcd_o}, {16'h0, ref_bcd(v)});
        check("ovf", {31'h0, overflow_o}, {31'h0, (v > 16'd9999)});
        check("ready_at_done", {31'h0, ready_o}, 32'd1);
        @(posedge clk); #1;
        check("done_pulse", {31'h0, done_o}, 32'd0);
        if (poke) begin
            extra = 0;
            repeat (25) begin
                @(posedge clk); #1;
                if (done_o) extra++;
            end
            check("single_done", extra, 0);
            check("bcd_hold", {16'h0, bcd_o}, {16'h0, ref_bcd(v)});
        end
    endtask

    initial begin
        int n;
        int dn;
        logic [15:0] v;

        rst_n  = 1'b0;
        start  = 1'b0;
        binary = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {31'h0, ready_o}, 32'd1);
        check("rst_done", {31'h0, done_o}, 32'd0);
        check("rst_bcd", {16'h0, bcd_o}, 32'd0);
        check("rst_ovf", {31'h0, overflow_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_conv(16'd0, 1'b0);
        do_conv(16'd1234, 1'b0);
        do_conv(16'd9999, 1'b0);
        do_conv(16'd10000, 1'b0);
        do_conv(16'd42, 1'b0);
        do_conv(16'd65535, 1'b0);
        do_conv(16'd57, 1'b1);

        // Free-running refresh: start held high, input changes after first capture.
        @(negedge clk);
        binary = 16'd5;
        start  = 1'b1;
        @(posedge clk); #1;
        binary = 16'd77;
        n = 0;
        while (n < 40) begin
            @(posedge clk); #1;
            n++;
            if (done_o) break;
        end
        check("b2b_lat", n, 17);
        check("b2b_bcd0", {16'h0, bcd_o}, {16'h0, ref_bcd(5)});
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b_accept", {31'h0, ready_o}, 32'd0);
        dn = 0;
        while (dn < 40) begin
            @(posedge clk); #1;
            dn++;
            if (done_o) break;
        end
        check("b2b_period", dn + 1, 18);
        check("b2b_bcd1", {16'h0, bcd_o}, {16'h0, ref_bcd(77)});
        @(posedge clk); #1;

        // Asynchronous abort partway through a conversion.
        @(negedge clk);
        binary = 16'd8888;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_ready", {31'h0, ready_o}, 32'd1);
        check("abort_bcd", {16'h0, bcd_o}, 32'd0);
        check("abort_done", {31'h0, done_o}, 32'd0);
        check("abort_ovf", {31'h0, overflow_o}, 32'd0);
        dn = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done_o) dn++;
        end
        check("abort_no_done", dn, 0);
        @(negedge clk);
        rst_n = 1'b1;
        do_conv(16'd65, 1'b0);

        for (int i = 0; i < 12; i++) begin
            v = (i % 2 == 0) ? 16'($urandom_range(0, 9999)) : 16'($urandom);
            do_conv(v, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_serial.md
# bin_to_bcd_serial

Sequential binary-to-BCD converter (shift-and-add-3 / double-dabble) with a start/done handshake. It sits downstream of the occupancy counter and feeds the 4-digit time-multiplexed display. It takes the 16-bit car count and produces packed BCD digits one conversion at a time. Inputs above the display range saturate the output to all nines and raise a flag.

## Interface
- `BIN_W`, default 16: width of the binary input; also the number of shift cycles.
- `DIGITS`, default 4: number of BCD digits produced.
- `clk_i` input 1: single clock; all state updates on the rising edge.
- `rst_ni` input 1: reset, asynchronous and active-low.
- `start_i` input 1: request a conversion; sampled only while `ready_o`=1.
- `binary_i` input BIN_W: value to convert; captured on the accepted start edge.
- `ready_o` output 1: high in IDLE only.
- `done_o` output 1: one-cycle pulse when `bcd_o` and `overflow_o` update.
- `bcd_o` output 4*DIGITS: packed BCD, digit 0 in bits [3:0]; holds its last result between conversions.
- `overflow_o` output 1: captured value exceeded 10^DIGITS−1; holds until the next `done_o`.

## Operation
- States:
  - IDLE: `ready_o`=1.
    - `start_i`=1 captures `binary_i` into the shift register, clears the BCD work register and loads the bit counter with BIN_W−1.
    - It also latches ovf_pend = (`binary_i` > 10^DIGITS−1), then moves to SHIFT.
  - SHIFT: each cycle, every work digit ≥5 gets +3, then {work, shift} shifts left by one.
    - The counter decrements after each shift.
    - On the shift done with counter=0, move to DONE.
  - DONE: registers the result and goes to IDLE.
    - If ovf_pend=0, `bcd_o` takes the work register.
    - If ovf_pend=1, `bcd_o` takes all digits = 4'h9.
    - `overflow_o` takes ovf_pend; `done_o`=1 for this one cycle.
  - default/illegal state: go to IDLE.
- Work register is DIGITS digits wide. Bits shifted out of the top digit are discarded; this only happens when ovf_pend=1, so the saturated result is unaffected.
- Width rules:
  - The comparison constant 10^DIGITS−1 is evaluated at elaboration.
  - If BIN_W cannot exceed it (2^BIN_W−1 ≤ 10^DIGITS−1), `overflow_o` is tied to 0 by construction.
- `start_i` outside IDLE is ignored; it is not queued. `binary_i` changes after capture have no effect.
- Upstream usage: the consumer pulses `start_i` whenever the count changes, or holds `start_i` high for free-running refresh.

## Timing
- Reset values: state IDLE, `ready_o`=1, `done_o`=0, `bcd_o`=0, `overflow_o`=0, counter and work/shift registers 0.
- Start accepted at edge k: SHIFT occupies edges k+1 … k+BIN_W.
- DONE: state is DONE after edge k+BIN_W; `done_o` is high, with new `bcd_o`/`overflow_o`, after edge k+BIN_W+1.
- `ready_o` is high again in that same cycle, so `done_o` and `ready_o` are simultaneously 1.
- Latency: BIN_W+1 edges from accepted start to `done_o` (17 for defaults).
- Throughput: one conversion per BIN_W+2 cycles.
- `start_i` held high gives back-to-back conversions: a new start is accepted on the edge where `done_o` is high.
- Reset asserted mid-conversion aborts immediately: outputs return to reset values, no `done_o`, and the previous `bcd_o` is lost (reads 0).
- Release of `rst_ni` is assumed synchronised externally. The first start is accepted no earlier than the first edge after release.

## Structure
- Package `display_pkg`:
  - state enum typedef (IDLE, SHIFT, DONE);
  - function `max_decimal(DIGITS)` returning 10^DIGITS−1;
  - constant `BCD_NINE` = 4'h9.
- Sub-module `bcd_digit_adjust`: combinational 4-bit in/out, +3 when ≥5, instantiated DIGITS times via generate.
- Top: one FSM, registers, counter width $clog2(BIN_W).

## Test plan
- Reset, then `binary_i`=0 with a start pulse → `done_o` high exactly 17 edges after start; `bcd_o`=16'h0000, `overflow_o`=0; `ready_o` low for cycles 1–16.
- `binary_i`=1234 → `bcd_o`=16'h1234. `binary_i`=9999 → 16'h9999 with `overflow_o`=0.
- `binary_i`=10000 → `bcd_o`=16'h9999, `overflow_o`=1. A following conversion of 42 → 16'h0042, `overflow_o`=0.
- Start with 57, then pulse `start_i` with 300 while busy and change `binary_i` → result 16'h0057, exactly one `done_o`.
- `start_i` held high, inputs 5 then 77 → `done_o` every 18 cycles, results 16'h0005 then 16'h0077.
- Drop `rst_ni` at SHIFT cycle 8 of a conversion of 8888 → immediately `ready_o`=1 and `bcd_o`=0; no `done_o`. After release, a conversion of 65 → 16'h0065.
